f_bus_rom: RTL and testbench
============================

# f_bus_rom

Instruction-memory responder on the Polaris F-bus (instruction fetch Wishbone bus), the slave end of the fetch stage's initiator. Decodes a word-address window, reads a synchronous on-chip memory and returns one 32-bit instruction per accepted request after a configurable number of wait states. A side load port lets a boot loader or debugger write memory contents. The default window covers the Polaris reset vector.

## Interface
- `BASE_ADR`, default 62'h3FFF_FFFF_FFFF_FF00: word address (bits [63:2]) of the window base; aligned to 2^`DEPTH_LOG2` words.
- `DEPTH_LOG2`, default 8: log2 of memory depth in 32-bit words (256 words = 1 KiB).
- `WAIT_STATES`, default 0: extra cycles inserted before ack, 0..15.
- `INIT_FILE`, default "": hex file for initial contents; empty means all zero.
- `clk_i`  in  1  clock; all logic rises on posedge.
- `reset_ni`  in  1  reset, asynchronous, active-low.
- `f_cyc_i`  in  1  F-bus cycle; implies STB and all four SEL bits.
- `f_adr_i`  in  [63:2]  F-bus word address.
- `f_ack_o`  out  1  F-bus acknowledge, one-cycle pulse per transfer.
- `f_dat_o`  out  [31:0]  instruction word; valid only while `f_ack_o`=1.
- `ld_we_i`  in  1  load-port write strobe.
- `ld_adr_i`  in  [DEPTH_LOG2-1:0]  load-port word index.
- `ld_dat_i`  in  [31:0]  load-port write data.

## Operation
- Hit: `f_adr_i[63:2+DEPTH_LOG2] == BASE_ADR[63:2+DEPTH_LOG2]`. Index is `f_adr_i[DEPTH_LOG2+1:2]`.
- The FSM has three states: IDLE, WAIT and ACK. A 4-bit wait counter and a latched request address support them.
- IDLE, on `f_cyc_i & hit & ~ld_we_i`:
  - Latch the address and capture `mem[index]` into the `f_dat_o` register.
  - Load the counter with `WAIT_STATES`.
  - Go to WAIT if `WAIT_STATES`>0, otherwise go to ACK.
  - In all other cases stay in IDLE.
- WAIT, abort: if `~f_cyc_i`, or `f_adr_i` differs from the latched address, or `ld_we_i`=1, go to IDLE with no ack.
- WAIT, otherwise: decrement the counter. When the counter equals 1, go to ACK, so WAIT lasts exactly `WAIT_STATES` cycles.
- ACK:
  - `f_ack_o = f_cyc_i`. If the initiator has dropped the cycle, the ack is suppressed.
  - Always return to IDLE on the next edge.
- Load writes:
  - When `ld_we_i`=1, write `mem[ld_adr_i] <= ld_dat_i` at the edge, in any state.
  - A write during ACK does not alter the already-captured `f_dat_o`.
- Miss (address outside the window): never acked. The initiator sees a permanent bubble. Decoding bus errors is out of scope.
- `f_dat_o` holds its last captured value outside ack.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, `f_ack_o`=0, `f_dat_o`=0, counter=0. Memory contents are retained.
- Latency: a request accepted in IDLE at cycle N is acked in cycle N+1+`WAIT_STATES`.
- Throughput: the initiator advances its address on the ack edge. Back-to-back fetches therefore cost 2+`WAIT_STATES` cycles each, because IDLE is always re-entered after ACK.
- `f_ack_o` never stays high for two consecutive cycles.
- Reset asserted mid-WAIT or mid-ACK forces IDLE immediately. No ack is issued for the in-flight request.
- Simultaneous `ld_we_i` and a new request in IDLE: the write wins and the request is not accepted that cycle. It is retried the next cycle and reads the newly written data if the index matches.
- Counter arithmetic is 4-bit. `WAIT_STATES`>15 is illegal (elaboration check).

## Test plan
- Reset vector fetch:
  - Stimulus: defaults; preload `mem[0xC0]`=32'h0000_0013; `reset_ni` low then high; `f_cyc_i`=1, `f_adr_i`=62'h3FFF_FFFF_FFFF_FFC0.
  - Required response: `f_ack_o`=1 exactly one cycle later with `f_dat_o`=32'h0000_0013.
- Wait states:
  - Stimulus: `WAIT_STATES`=3; request index 0x05 holding 32'hDEAD_BEEF.
  - Required response: ack in cycle N+4 with `f_dat_o`=32'hDEAD_BEEF; `f_ack_o`=0 during N+1..N+3.
- Sequential stream:
  - Stimulus: indices 0x00..0x03 loaded with 1,2,3,4; drive a model of the fetch initiator that increments the address on ack.
  - Required response: four acks 2 cycles apart with data 1,2,3,4.
- Miss:
  - Stimulus: `f_adr_i`=62'h0000_0000_0000_0010 held for 20 cycles.
  - Required response: `f_ack_o` stays 0.
- Abort:
  - Stimulus: `WAIT_STATES`=2; change the address in the first WAIT cycle.
  - Required response: no ack for the first address; new request acked 3 cycles after re-acceptance.
  - Stimulus: repeat with `ld_we_i` pulsed during WAIT.
  - Required response: same abort and re-accept behaviour.
- Async reset mid-transfer:
  - Stimulus: `WAIT_STATES`=5; drop `reset_ni` between clock edges during WAIT.
  - Required response: `f_ack_o`=0 and `f_dat_o`=0 immediately; no ack after release until a fresh request is accepted.

Source files
------------

// File: rtl/f_bus_rom.sv
// Polaris F-bus instruction memory responder: window decode, synchronous read,
// programmable wait states and a side load port for boot loader / debugger writes.
module f_bus_rom #(
   parameter logic [63:2] BASE_ADR    = 62'h3FFF_FFFF_FFFF_FF00,
   parameter int          DEPTH_LOG2  = 8,
   parameter int          WAIT_STATES = 0,
   parameter              INIT_FILE   = ""
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  f_cyc_i,
   input  logic [63:2]           f_adr_i,
   output logic                  f_ack_o,
   output logic [31:0]           f_dat_o,
   input  logic                  ld_we_i,
   input  logic [DEPTH_LOG2-1:0] ld_adr_i,
   input  logic [31:0]           ld_dat_i
);

   localparam int         DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0] WS    = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t                state, next_state;
   logic [3:0]            count, next_count;
   logic [63:2]           lat_adr;
   logic [31:0]           mem [DEPTH];
   logic                  hit, accept;
   logic [DEPTH_LOG2-1:0] index;

   generate
      if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
         $error("f_bus_rom: WAIT_STATES must be within 0..15");
      end
   endgenerate

   assign hit    = (f_adr_i[63:2+DEPTH_LOG2] == BASE_ADR[63:2+DEPTH_LOG2]);
   assign index  = f_adr_i[DEPTH_LOG2+1:2];
   // A load-port write in the same cycle wins; the fetch simply retries next cycle.
   assign accept = (state == S_IDLE) && f_cyc_i && hit && !ld_we_i;

   always_comb begin
      next_state = state;
      next_count = count;
      f_ack_o    = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               next_count = WS;
               next_state = (WS != 4'd0) ? S_WAIT : S_ACK;
            end
         end
         S_WAIT: begin
            if (!f_cyc_i || (f_adr_i != lat_adr) || ld_we_i) begin
               next_state = S_IDLE;
            end else begin
               next_count = count - 4'd1;
               if (count == 4'd1) begin
                  next_state = S_ACK;
               end
            end
         end
         S_ACK: begin
            f_ack_o    = f_cyc_i;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state   <= S_IDLE;
         count   <= 4'd0;
         lat_adr <= '0;
         f_dat_o <= 32'd0;
      end else begin
         state <= next_state;
         count <= next_count;
         if (accept) begin
            lat_adr <= f_adr_i;
            f_dat_o <= mem[index];
         end
      end
   end

   // Memory has no reset so boot-loaded contents survive a core reset.
   always_ff @(posedge clk_i) begin
      if (ld_we_i) begin
         mem[ld_adr_i] <= ld_dat_i;
      end
   end

endmodule

// File: tb/tb_f_bus_rom.sv
// Scoreboard bench for f_bus_rom: four instances (0, 2, 3 and 5 wait states)
// share all inputs; each test watches the instance whose timing it exercises.
module tb_f_bus_rom;

   localparam logic [63:2] BASE = 62'h3FFF_FFFF_FFFF_FF00;

   typedef struct {
      int          cyc;
      logic [31:0] dat;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        f_cyc;
   logic [63:2] f_adr;
   logic        ld_we;
   logic [7:0]  ld_adr;
   logic [31:0] ld_dat;
   logic        ack [4];
   logic [31:0] dat [4];

   int   checks   = 0;
   int   failures = 0;
   int   now      = 0;
   exp_t sb[$];

   generate
      for (genvar g = 0; g < 4; g++) begin : g_dut
         f_bus_rom #(
            .WAIT_STATES(g == 0 ? 0 : g == 1 ? 2 : g == 2 ? 3 : 5)
         ) dut (
            .clk_i   (clk),
            .reset_ni(rst_n),
            .f_cyc_i (f_cyc),
            .f_adr_i (f_adr),
            .f_ack_o (ack[g]),
            .f_dat_o (dat[g]),
            .ld_we_i (ld_we),
            .ld_adr_i(ld_adr),
            .ld_dat_i(ld_dat)
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:2] adr_of(input int idx);
      return BASE + 62'(idx);
   endfunction

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      now++;
   endtask

   task automatic load(input int idx, input logic [31:0] d);
      ld_we  = 1'b1;
      ld_adr = 8'(idx);
      ld_dat = d;
      step();
      ld_we  = 1'b0;
   endtask

   task automatic pulse_reset();
      f_cyc = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      sb.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (ack[d] !== 1'b0 || dat[d] !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_state dut%0d: got ack=%b dat=%h, expected ack=0 dat=00000000", d, ack[d], dat[d]);
         end
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset_vector();
      exp_t e;
      load(8'hC0, 32'h0000_0013);
      pulse_reset();
      f_cyc = 1'b1;
      f_adr = 62'h3FFF_FFFF_FFFF_FFC0;
      sb.push_back('{now + 1, 32'h0000_0013});
      for (int k = 0; k < 6; k++) begin
         step();
         if (ack[0]) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("[TB] FAIL reset_vector_extra_ack: got ack at cycle %0d, expected none", now);
            end else begin
               e = sb.pop_front();
               if (now !== e.cyc || dat[0] !== e.dat) begin
                  failures++;
                  $display("[TB] FAIL reset_vector_ack: got cycle=%0d dat=%h, expected cycle=%0d dat=%h", now, dat[0], e.cyc, e.dat);
               end
            end
            f_cyc = 1'b0;
         end
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL reset_vector_missing_ack: got %0d outstanding, expected 0", sb.size());
      end
   endtask

   task automatic test_wait_states();
      exp_t e;
      load(5, 32'hDEAD_BEEF);
      pulse_reset();
      f_cyc = 1'b1;
      f_adr = adr_of(5);
      sb.push_back('{now + 4, 32'hDEAD_BEEF});
      for (int k = 0; k < 8; k++) begin
         step();
         if (ack[2]) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("[TB] FAIL wait_states_extra_ack: got ack at cycle %0d, expected none", now);
            end else begin
               e = sb.pop_front();
               if (now !== e.cyc || dat[2] !== e.dat) begin
                  failures++;
                  $display("[TB] FAIL wait_states_ack: got cycle=%0d dat=%h, expected cycle=%0d dat=%h", now, dat[2], e.cyc, e.dat);
               end
            end
            f_cyc = 1'b0;
         end
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL wait_states_missing_ack: got %0d outstanding, expected 0", sb.size());
      end
   endtask

   task automatic test_stream();
      exp_t e;
      int   idx;
      for (int i = 0; i < 4; i++) load(i, 32'(i + 1));
      pulse_reset();
      idx   = 0;
      f_cyc = 1'b1;
      f_adr = adr_of(0);
      sb.push_back('{now + 1, 32'd1});
      for (int k = 0; k < 20; k++) begin
         step();
         if (ack[0]) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("[TB] FAIL stream_extra_ack: got ack at cycle %0d, expected none", now);
            end else begin
               e = sb.pop_front();
               if (now !== e.cyc || dat[0] !== e.dat) begin
                  failures++;
                  $display("[TB] FAIL stream_ack: got cycle=%0d dat=%h, expected cycle=%0d dat=%h", now, dat[0], e.cyc, e.dat);
               end
            end
            idx++;
            if (idx < 4) begin
               f_adr = adr_of(idx);
               sb.push_back('{now + 2, 32'(idx + 1)});
            end else begin
               f_cyc = 1'b0;
            end
         end
      end
      checks++;
      if (idx != 4 || sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL stream_count: got acks=%0d outstanding=%0d, expected acks=4 outstanding=0", idx, sb.size());
      end
   endtask

   task automatic test_miss();
      pulse_reset();
      f_cyc = 1'b1;
      f_adr = 62'h0000_0000_0000_0010;
      for (int k = 0; k < 20; k++) begin
         step();
         checks++;
         if ((ack[0] | ack[1] | ack[2] | ack[3]) !== 1'b0) begin
            failures++;
            $display("[TB] FAIL miss_ack cycle %0d: got ack=%b%b%b%b, expected 0000", now, ack[3], ack[2], ack[1], ack[0]);
         end
      end
      f_cyc = 1'b0;
   endtask

   task automatic test_abort();
      exp_t e;
      load(7, 32'hA7A7_0007);
      load(8, 32'h0808_0808);
      pulse_reset();
      for (int pass = 0; pass < 2; pass++) begin
         f_cyc = 1'b1;
         f_adr = adr_of(7);
         step();
         if (pass == 0) begin
            f_adr = adr_of(8);
            sb.push_back('{now + 4, 32'h0808_0808});
         end else begin
            ld_we  = 1'b1;
            ld_adr = 8'd7;
            ld_dat = 32'h7777_0000;
            sb.push_back('{now + 4, 32'h7777_0000});
         end
         for (int k = 0; k < 10; k++) begin
            step();
            ld_we = 1'b0;
            if (ack[1]) begin
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("[TB] FAIL abort%0d_extra_ack: got ack at cycle %0d, expected none", pass, now);
               end else begin
                  e = sb.pop_front();
                  if (now !== e.cyc || dat[1] !== e.dat) begin
                     failures++;
                     $display("[TB] FAIL abort%0d_ack: got cycle=%0d dat=%h, expected cycle=%0d dat=%h", pass, now, dat[1], e.cyc, e.dat);
                  end
               end
               f_cyc = 1'b0;
            end
         end
         checks++;
         if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL abort%0d_missing_ack: got %0d outstanding, expected 0", pass, sb.size());
         end
         sb.delete();
      end
   endtask

   task automatic test_load_priority();
      exp_t e;
      pulse_reset();
      f_cyc  = 1'b1;
      f_adr  = adr_of(8'h20);
      ld_we  = 1'b1;
      ld_adr = 8'h20;
      ld_dat = 32'h1234_5678;
      sb.push_back('{now + 2, 32'h1234_5678});
      for (int k = 0; k < 6; k++) begin
         step();
         ld_we = 1'b0;
         if (ack[0]) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("[TB] FAIL load_priority_extra_ack: got ack at cycle %0d, expected none", now);
            end else begin
               e = sb.pop_front();
               if (now !== e.cyc || dat[0] !== e.dat) begin
                  failures++;
                  $display("[TB] FAIL load_priority_ack: got cycle=%0d dat=%h, expected cycle=%0d dat=%h", now, dat[0], e.cyc, e.dat);
               end
            end
            f_cyc = 1'b0;
         end
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL load_priority_missing_ack: got %0d outstanding, expected 0", sb.size());
      end
   endtask

   task automatic test_ack_drop();
      pulse_reset();
      f_cyc = 1'b1;
      f_adr = adr_of(8'h20);
      step();
      checks++;
      if (ack[0] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ack_drop_pre: got ack=%b, expected 1", ack[0]);
      end
      f_cyc = 1'b0;
      #1;
      checks++;
      if (ack[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ack_drop_suppress: got ack=%b, expected 0", ack[0]);
      end
      step();
      checks++;
      if (ack[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ack_drop_after: got ack=%b, expected 0", ack[0]);
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      load(8'h11, 32'h1111_1111);
      pulse_reset();
      f_cyc = 1'b1;
      f_adr = adr_of(8'h11);
      step();
      step();
      checks++;
      if (dat[3] !== 32'h1111_1111 || ack[3] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL async_capture: got ack=%b dat=%h, expected ack=0 dat=11111111", ack[3], dat[3]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (ack[d] !== 1'b0 || dat[d] !== 32'd0) begin
            failures++;
            $display("[TB] FAIL async_reset dut%0d: got ack=%b dat=%h, expected ack=0 dat=00000000", d, ack[d], dat[d]);
         end
      end
      f_cyc = 1'b0;
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         checks++;
         if (ack[3] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_stale_ack cycle %0d: got ack=%b, expected 0", now, ack[3]);
         end
      end
      f_cyc = 1'b1;
      sb.push_back('{now + 6, 32'h1111_1111});
      for (int k = 0; k < 12; k++) begin
         step();
         if (ack[3]) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("[TB] FAIL async_extra_ack: got ack at cycle %0d, expected none", now);
            end else begin
               e = sb.pop_front();
               if (now !== e.cyc || dat[3] !== e.dat) begin
                  failures++;
                  $display("[TB] FAIL async_fresh_ack: got cycle=%0d dat=%h, expected cycle=%0d dat=%h", now, dat[3], e.cyc, e.dat);
               end
            end
            f_cyc = 1'b0;
         end
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL async_missing_ack: got %0d outstanding, expected 0", sb.size());
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      f_cyc  = 1'b0;
      f_adr  = '0;
      ld_we  = 1'b0;
      ld_adr = '0;
      ld_dat = '0;
      @(negedge clk);
      test_reset();
      test_reset_vector();
      test_wait_states();
      test_stream();
      test_miss();
      test_abort();
      test_load_priority();
      test_ack_drop();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
